receptor_serial_7bits: RTL and testbench



---
 rtl/receptor_pkg.sv | 15 +
 rtl/deslocador_sipo.sv | 19 +
 rtl/receptor_serial_7bits.sv | 98 +++++++++
 tb/tb_receptor_serial_7bits.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/receptor_pkg.sv
// Shared types and line-level constants for the serial receiver.
package receptor_pkg;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      DADOS    = 2'd1,
      PARIDADE = 2'd2,
      PARADA   = 2'd3
   } estado_t;

   localparam logic START_BIT    = 1'b1;
   localparam logic STOP_BIT     = 1'b0;
   localparam logic LINHA_OCIOSA = 1'b0;

endpackage

// File: rtl/deslocador_sipo.sv
// N_BITS serial-in/parallel-out shift register, MSB arrives first.
module deslocador_sipo #(
   parameter int N_BITS = 7
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              en,
   input  logic              din,
   output logic [N_BITS-1:0] q
);

   always_ff @(posedge clk) begin
      if (!clr_n)
         q <= '0;
      else if (en)
         q <= {q[N_BITS-2:0], din};
   end

endmodule

// File: rtl/receptor_serial_7bits.sv
// Serial frame receiver: start, N_BITS data MSB first, optional parity, stop.
// Define RECEPTOR_PARIDADE_EN to require an even-parity bit before the stop bit.
module receptor_serial_7bits
   import receptor_pkg::*;
#(
   parameter int N_BITS = 7,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              amostra,
   input  logic              bit_serial,
   output logic [N_BITS-1:0] dados,
   output logic              valido,
   output logic              ocupado,
   output logic              erro_quadro
);

   estado_t             estado;
   logic [CNT_W-1:0]    cnt;
   logic [N_BITS-1:0]   shift_q;
   logic                shift_en;
`ifdef RECEPTOR_PARIDADE_EN
   logic                erro_par;
`endif

   assign shift_en = amostra && (estado == DADOS);
   assign ocupado  = (estado != OCIOSO);

   deslocador_sipo #(.N_BITS(N_BITS)) u_desl (
      .clk   (clk),
      .clr_n (rst_n),
      .en    (shift_en),
      .din   (bit_serial),
      .q     (shift_q)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado      <= OCIOSO;
         cnt         <= '0;
         dados       <= '0;
         valido      <= 1'b0;
         erro_quadro <= 1'b0;
`ifdef RECEPTOR_PARIDADE_EN
         erro_par    <= 1'b0;
`endif
      end else begin
         valido      <= 1'b0;
         erro_quadro <= 1'b0;
         if (amostra) begin
            case (estado)
               OCIOSO: begin
                  if (bit_serial == START_BIT) begin
                     estado <= DADOS;
                     cnt    <= '0;
`ifdef RECEPTOR_PARIDADE_EN
                     erro_par <= 1'b0;
`endif
                  end
               end
               DADOS: begin
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(N_BITS - 1)) begin
`ifdef RECEPTOR_PARIDADE_EN
                     estado <= PARIDADE;
`else
                     estado <= PARADA;
`endif
                  end
               end
`ifdef RECEPTOR_PARIDADE_EN
               PARIDADE: begin
                  // Data plus parity must XOR to zero (even parity).
                  erro_par <= ^{shift_q, bit_serial};
                  estado   <= PARADA;
               end
`endif
               PARADA: begin
`ifdef RECEPTOR_PARIDADE_EN
                  if (bit_serial == STOP_BIT && !erro_par) begin
`else
                  if (bit_serial == STOP_BIT) begin
`endif
                     dados  <= shift_q;
                     valido <= 1'b1;
                  end else begin
                     erro_quadro <= 1'b1;
                  end
                  estado <= OCIOSO;
               end
               default: estado <= OCIOSO;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_receptor_serial_7bits.sv
// Scoreboard bench for receptor_serial_7bits: driver queues expected outcomes, monitor checks pulses.
module tb_receptor_serial_7bits;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       amostra;
   logic       bit_serial;
   logic [6:0] dados;
   logic       valido;
   logic       ocupado;
   logic       erro_quadro;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit       is_err;
      bit [6:0] dados;
   } exp_t;

   exp_t     sb[$];
   bit [6:0] last_good;

   receptor_serial_7bits dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .amostra     (amostra),
      .bit_serial  (bit_serial),
      .dados       (dados),
      .valido      (valido),
      .ocupado     (ocupado),
      .erro_quadro (erro_quadro)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // One strobe after `gap` non-strobe cycles; returns just after the edge that sampled it.
   task automatic send_bit(bit b, int gap);
      repeat (gap) begin
         amostra    = 1'b0;
         bit_serial = 1'($urandom);
         @(posedge clk); #1;
      end
      amostra    = 1'b1;
      bit_serial = b;
      @(posedge clk); #1;
      amostra    = 1'b0;
      bit_serial = 1'($urandom);
   endtask

   // Reference model: a frame is good iff stop is 0 and (with parity) data^parity is even.
   task automatic send_frame(bit [6:0] d, bit stop, bit par, int gap);
      bit ok;
      exp_t e;
      send_bit(1'b1, gap);
      check("ocupado_after_start", ocupado, 1'b1);
      for (int i = 6; i >= 0; i--) send_bit(d[i], gap);
`ifdef RECEPTOR_PARIDADE_EN
      send_bit(par, gap);
      ok = (stop == 1'b0) && ((^d ^ par) == 1'b0);
`else
      ok = (stop == 1'b0);
`endif
      if (ok) last_good = d;
      e.is_err = !ok;
      e.dados  = last_good;
      sb.push_back(e);
      send_bit(stop, gap);
      check("ocupado_after_stop", ocupado, 1'b0);
   endtask

   // Monitor: every pulse must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (valido && erro_quadro) check("pulses_exclusive", 1, 0);
         if (valido || erro_quadro) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", {valido, erro_quadro}, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("pulse_kind_err", erro_quadro, e.is_err);
               check("pulse_kind_ok", valido, !e.is_err);
               check("dados", dados, e.dados);
            end
         end
      end
   end

   initial begin
      bit [6:0] d;
      rst_n      = 1'b0;
      amostra    = 1'b0;
      bit_serial = 1'b0;
      last_good  = '0;
      repeat (3) begin
         amostra    = 1'($urandom);
         bit_serial = 1'($urandom);
         @(posedge clk); #1;
      end
      check("rst_dados", dados, 0);
      check("rst_valido", valido, 0);
      check("rst_ocupado", ocupado, 0);
      check("rst_erro", erro_quadro, 0);
      rst_n   = 1'b1;
      amostra = 1'b0;
      repeat (2) @(posedge clk); #1;

      send_frame(7'h53, 1'b0, 1'b0, 3);
      send_frame(7'b0110001, 1'b1, 1'b1, 3);
      send_frame(7'h7F, 1'b0, 1'b1, 3);
      send_frame(7'h00, 1'b0, 1'b0, 0);

      // Abort after the third data strobe.
      send_bit(1'b1, 3);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      last_good = '0;
      check("midrst_dados", dados, 0);
      check("midrst_ocupado", ocupado, 0);
      check("midrst_valido", valido, 0);
      check("midrst_erro", erro_quadro, 0);
      repeat (4) @(posedge clk); #1;
      send_frame(7'h2A, 1'b0, 1'b1, 3);

`ifdef RECEPTOR_PARIDADE_EN
      send_frame(7'h53, 1'b0, 1'b0, 3);
      send_frame(7'h53, 1'b0, 1'b1, 3);
`endif

      for (int f = 0; f < 30; f++) begin
         int idle;
         idle = int'($urandom_range(0, 2));
         for (int k = 0; k < idle; k++) send_bit(1'b0, int'($urandom_range(0, 3)));
         d = 7'($urandom);
         send_frame(d, ($urandom_range(0, 4) == 0), (^d) ^ ($urandom_range(0, 4) == 0),
                    int'($urandom_range(0, 3)));
      end

      for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
      repeat (2) @(posedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
